// File: rtl/pingpong_pkg.sv
// Shared types and defaults for the ping-pong buffer scheduler.
package pingpong_pkg;

  localparam int unsigned DATA_W_DEF = 8;
  localparam int unsigned ADDR_W_DEF = 8;

  // Reader FSM: wait for a full bank, then stream it out.
  typedef enum logic {
    R_IDLE  = 1'b0,
    R_DRAIN = 1'b1
  } rd_state_t;

  // Index of one of the two RAM banks.
  typedef logic bank_t;

endpackage

// File: rtl/pp_skid_buf.sv
// Two-entry FIFO holding RAM read data plus its last-word tag.
// The head register drives the output port directly.
module pp_skid_buf #(
  parameter int unsigned W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         pop,
  output logic         head_valid,
  output logic [W-1:0] head_data,
  output logic [1:0]   occ
);

  logic [W-1:0] ent0;
  logic [W-1:0] ent1;
  logic [1:0]   cnt;
  logic         do_pop;

  assign do_pop     = pop && (cnt != 2'd0);
  assign head_valid = (cnt != 2'd0);
  assign head_data  = ent0;
  assign occ        = cnt;

  // Entry 0 is always the head; entry 1 only holds the second word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0 <= '0;
      ent1 <= '0;
      cnt  <= '0;
    end else begin
      case (cnt)
        2'd0: begin
          if (push) begin
            ent0 <= push_data;
            cnt  <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, do_pop})
            2'b11: ent0 <= push_data;
            2'b10: begin
              ent1 <= push_data;
              cnt  <= 2'd2;
            end
            2'b01: cnt <= 2'd0;
            default: ;
          endcase
        end
        default: begin
          if (do_pop) begin
            ent0 <= ent1;
            if (push) ent1 <= push_data;
            else      cnt  <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: rtl/pingpong_sched.sv
// Ping-pong buffer controller: fills two RAM banks alternately from an
// input stream and streams each completed bank out through a skid FIFO.
module pingpong_sched
  import pingpong_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              ram0_wr_en,
  output logic              ram1_wr_en,
  output logic [ADDR_W-1:0] ram0_wr_addr,
  output logic [ADDR_W-1:0] ram1_wr_addr,
  output logic [DATA_W-1:0] ram0_wr_data,
  output logic [DATA_W-1:0] ram1_wr_data,
  output logic              ram0_rd_en,
  output logic              ram1_rd_en,
  output logic [ADDR_W-1:0] ram0_rd_addr,
  output logic [ADDR_W-1:0] ram1_rd_addr,
  input  logic [DATA_W-1:0] ram0_rd_data,
  input  logic [DATA_W-1:0] ram1_rd_data,
  output logic              wr_bank,
  output logic              rd_bank,
  output logic [15:0]       swap_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  logic [1:0]        full;
  logic [1:0]        full_nxt;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  rd_state_t         rd_state;

  logic              wr_fire;
  logic              wr_last;
  logic              rd_issue;
  logic              rd_last;

  logic              q_vld;
  bank_t             q_bank;
  logic              q_last;
  logic [DATA_W:0]   q_word;
  logic [DATA_W:0]   head_word;
  logic [1:0]        fifo_occ;
  logic              fifo_pop;
  logic [2:0]        credit_use;

  assign in_ready = !full[wr_bank];
  assign wr_fire  = in_valid && in_ready;
  assign wr_last  = wr_fire && (wr_ptr == LAST_ADDR);

  // Writer: registered RAM write port, address counter, bank toggle.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      ram0_wr_en   <= 1'b0;
      ram1_wr_en   <= 1'b0;
      ram0_wr_addr <= '0;
      ram1_wr_addr <= '0;
      ram0_wr_data <= '0;
      ram1_wr_data <= '0;
      wr_ptr       <= '0;
      wr_bank      <= 1'b0;
      swap_cnt     <= '0;
    end else begin
      ram0_wr_en <= 1'b0;
      ram1_wr_en <= 1'b0;
      if (wr_fire) begin
        if (wr_bank) begin
          ram1_wr_en   <= 1'b1;
          ram1_wr_addr <= wr_ptr;
          ram1_wr_data <= in_data;
        end else begin
          ram0_wr_en   <= 1'b1;
          ram0_wr_addr <= wr_ptr;
          ram0_wr_data <= in_data;
        end
        wr_ptr <= wr_ptr + ADDR_W'(1);
        if (wr_ptr == LAST_ADDR) begin
          wr_bank  <= ~wr_bank;
          swap_cnt <= swap_cnt + 16'd1;
        end
      end
    end
  end

  // Bank full flags: writer sets its bank, reader clears its bank.
  // The two always refer to different banks when they coincide.
  always_comb begin
    full_nxt = full;
    if (wr_last) full_nxt[wr_bank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  // Full flag storage.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) full <= '0;
    else            full <= full_nxt;
  end

  // Credit counts the word leaving the FIFO this cycle, so the read
  // pipeline sustains one word per cycle with only two entries.
  assign fifo_pop   = out_valid && out_ready;
  assign credit_use = 3'(fifo_occ) + 3'(q_vld) - 3'(fifo_pop);

  // Read enables are combinational so a credit freed this cycle is
  // used this cycle; the address is the registered read pointer.
  assign rd_issue     = (rd_state == R_DRAIN) && (credit_use < 3'd2);
  assign rd_last      = rd_issue && (rd_ptr == LAST_ADDR);
  assign ram0_rd_en   = rd_issue && !rd_bank;
  assign ram1_rd_en   = rd_issue && rd_bank;
  assign ram0_rd_addr = rd_ptr;
  assign ram1_rd_addr = rd_ptr;

  // Reader FSM plus tracking of the read whose data appears on q.
  // IDLE also looks at the bank being completed this edge so the first
  // read issues the cycle after the final write handshake.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_state <= R_IDLE;
      rd_ptr   <= '0;
      rd_bank  <= 1'b0;
      q_vld    <= 1'b0;
      q_bank   <= 1'b0;
      q_last   <= 1'b0;
    end else begin
      q_vld <= rd_issue;
      if (rd_issue) begin
        q_bank <= rd_bank;
        q_last <= (rd_ptr == LAST_ADDR);
      end
      case (rd_state)
        R_IDLE: begin
          if (full[rd_bank] || (wr_last && (wr_bank == rd_bank)))
            rd_state <= R_DRAIN;
        end
        R_DRAIN: begin
          if (rd_issue) begin
            rd_ptr <= rd_ptr + ADDR_W'(1);
            if (rd_ptr == LAST_ADDR) begin
              rd_bank  <= ~rd_bank;
              rd_state <= R_IDLE;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  assign q_word = {q_last, (q_bank ? ram1_rd_data : ram0_rd_data)};

  pp_skid_buf #(
    .W (DATA_W + 1)
  ) u_skid (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .push       (q_vld),
    .push_data  (q_word),
    .pop        (out_ready),
    .head_valid (out_valid),
    .head_data  (head_word),
    .occ        (fifo_occ)
  );

  assign out_last = head_word[DATA_W];
  assign out_data = head_word[DATA_W-1:0];

endmodule
